// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared JK excitation codes and sequencer state type
package jk_pkg;

    // {j,k} excitation codes driven onto one flop of the bank
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Sequencer phases: each step is one DRIVE cycle followed by one CHECK cycle
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10,
        ST_DONE  = 2'b11
    } jk_state_e;

endpackage

// File: rtl/jk_excite.sv
// rtl/jk_excite.sv - one-bit JK excitation from current and target state
module jk_excite
    import jk_pkg::*;
(
    input  logic       q,
    input  logic       t,
    input  logic       use_toggle,
    output logic [1:0] jk
);

    // Hold when the bit already matches; otherwise set/reset, or toggle when requested
    always_comb begin
        jk = JK_HOLD;
        if (q != t) begin
            if (use_toggle) begin
                jk = JK_TGL;
            end else if (t) begin
                jk = JK_SET;
            end else begin
                jk = JK_RST;
            end
        end
    end

endmodule

// File: rtl/jk_seq_driver.sv
// rtl/jk_seq_driver.sv - sequences an external JK flop bank through a target table and checks it
module jk_seq_driver
    import jk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 8,
    parameter int USE_TOGGLE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     len,
    input  logic [WIDTH-1:0]           q_fb,
    output logic [WIDTH-1:0]           j,
    output logic [WIDTH-1:0]           k,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(DEPTH)-1:0]   err_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic          USE_TGL = (USE_TOGGLE != 0);
    localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LEN_ONE = {{(LW-1){1'b0}}, 1'b1};

    jk_state_e         state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [LW-1:0]     len_q, len_d;
    logic              err_q, err_d;
    logic [AW-1:0]     err_idx_q, err_idx_d;
    logic [WIDTH-1:0]  table_q [DEPTH];
    logic [WIDTH-1:0]  table_d [DEPTH];

    logic [WIDTH-1:0]  target;
    logic [1:0]        code [WIDTH];
    logic              last_step;
    logic              mismatch;

    assign target    = table_q[idx_q];
    assign last_step = ({1'b0, idx_q} == (len_q - LEN_ONE));
    assign mismatch  = (q_fb != target);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        jk_excite u_excite (
            .q          (q_fb[gi]),
            .t          (target[gi]),
            .use_toggle (USE_TGL),
            .jk         (code[gi])
        );
    end

    // Excitation reaches the bank only during DRIVE; every other phase holds the bank
    always_comb begin
        j = '0;
        k = '0;
        if (state_q == ST_DRIVE) begin
            for (int i = 0; i < WIDTH; i++) begin
                j[i] = code[i][1];
                k[i] = code[i][0];
            end
        end
    end

    // Next-state logic: table writes in IDLE, run control, and the post-step comparison
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        table_d   = table_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    table_d[wr_addr] = wr_data;
                end
                if (start) begin
                    err_d = 1'b0;
                    if (len != '0) begin
                        len_d     = len;
                        idx_d     = '0;
                        err_idx_d = '0;
                        state_d   = ST_DRIVE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DRIVE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                    state_d   = ST_IDLE;
                end else if (last_step) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, run registers and the target table; reset abandons any run and clears the table
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;
    assign err_idx = err_idx_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// tb/tb_jk_seq_driver.sv - randomized self-checking bench for jk_seq_driver
module tb_jk_seq_driver;

    localparam int W  = 2;
    localparam int D  = 4;
    localparam int AW = 2;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          start;
    logic [LW-1:0] len;
    logic [W-1:0]  qfb0, qfb1, j0, k0, j1, k1;
    logic          busy0, busy1, done0, done1, err0, err1;
    logic [AW-1:0] eidx0, eidx1;

    logic [W-1:0]  bank0, bank1, stuck, load_val;
    logic          load_en;

    logic [W-1:0]  m_table [D];
    logic          m_err;
    logic [AW-1:0] m_eidx;
    logic [W-1:0]  m_q;
    int            n_vec = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    jk_seq_driver #(.WIDTH(W), .DEPTH(D), .USE_TOGGLE(0)) u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .q_fb(qfb0), .j(j0), .k(k0),
        .busy(busy0), .done(done0), .err(err0), .err_idx(eidx0)
    );

    jk_seq_driver #(.WIDTH(W), .DEPTH(D), .USE_TOGGLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .q_fb(qfb1), .j(j1), .k(k1),
        .busy(busy1), .done(done1), .err(err1), .err_idx(eidx1)
    );

    assign qfb0 = bank0 & ~stuck;
    assign qfb1 = bank1 & ~stuck;

    // External JK flop banks, one per DUT, with a preload path
    always @(posedge clk) begin
        if (load_en) begin
            bank0 <= load_val;
            bank1 <= load_val;
        end else begin
            bank0 <= (j0 & ~bank0) | (~k0 & bank0);
            bank1 <= (j1 & ~bank1) | (~k1 & bank1);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] exp_jk(input logic [W-1:0] q, input logic [W-1:0] t,
                                              input bit tgl);
        logic [W-1:0] chg;
        chg = q ^ t;
        if (tgl) return {chg, chg};
        return {t & chg, q & chg};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic b, input logic d,
                            input logic [W-1:0] je0, input logic [W-1:0] ke0,
                            input logic [W-1:0] je1, input logic [W-1:0] ke1);
        check({tag, "_j0"}, 32'(j0), 32'(je0));
        check({tag, "_k0"}, 32'(k0), 32'(ke0));
        check({tag, "_j1"}, 32'(j1), 32'(je1));
        check({tag, "_k1"}, 32'(k1), 32'(ke1));
        check({tag, "_busy0"}, 32'(busy0), 32'(b));
        check({tag, "_busy1"}, 32'(busy1), 32'(b));
        check({tag, "_done0"}, 32'(done0), 32'(d));
        check({tag, "_done1"}, 32'(done1), 32'(d));
        check({tag, "_err0"}, 32'(err0), 32'(m_err));
        check({tag, "_err1"}, 32'(err1), 32'(m_err));
        check({tag, "_eidx0"}, 32'(eidx0), 32'(m_eidx));
        check({tag, "_eidx1"}, 32'(eidx1), 32'(m_eidx));
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [W-1:0] dval);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = dval;
        tick();
        wr_en = 1'b0;
        m_table[a] = dval;
    endtask

    task automatic load_bank(input logic [W-1:0] v);
        load_en  = 1'b1;
        load_val = v;
        tick();
        load_en = 1'b0;
        m_q = v;
    endtask

    // One run of n steps; the model expects the bank to land on each target,
    // seen through the stuck-at-0 mask, and aborts at the first step it cannot reach
    task automatic run(input int n, input logic [W-1:0] stk, input bit poke);
        logic [W-1:0]   t, fb;
        logic [2*W-1:0] e0, e1;
        stuck = stk;
        chk_outs("pre", 1'b0, 1'b0, '0, '0, '0, '0);
        start = 1'b1;
        len   = LW'(n);
        tick();
        start = 1'b0;
        m_err = 1'b0;
        if (n > 0) m_eidx = '0;
        if (n == 0) begin
            chk_outs("len0", 1'b1, 1'b1, '0, '0, '0, '0);
            tick();
            chk_outs("len0_post", 1'b0, 1'b0, '0, '0, '0, '0);
            stuck = '0;
            return;
        end
        for (int s = 0; s < n; s++) begin
            t  = m_table[s];
            fb = m_q & ~stk;
            e0 = exp_jk(fb, t, 1'b0);
            e1 = exp_jk(fb, t, 1'b1);
            if (poke && s == 0) begin
                wr_en   = 1'b1;
                wr_addr = AW'($urandom);
                wr_data = W'($urandom);
                start   = 1'b1;
                len     = LW'($urandom_range(1, D));
            end
            chk_outs("drive", 1'b1, 1'b0, e0[2*W-1:W], e0[W-1:0], e1[2*W-1:W], e1[W-1:0]);
            tick();
            wr_en = 1'b0;
            start = 1'b0;
            m_q   = t;
            chk_outs("check", 1'b1, 1'b0, '0, '0, '0, '0);
            if ((t & ~stk) != t) begin
                tick();
                m_err  = 1'b1;
                m_eidx = AW'(s);
                chk_outs("abort", 1'b0, 1'b0, '0, '0, '0, '0);
                stuck = '0;
                return;
            end
            tick();
        end
        chk_outs("done", 1'b1, 1'b1, '0, '0, '0, '0);
        tick();
        chk_outs("post", 1'b0, 1'b0, '0, '0, '0, '0);
        stuck = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] seq [4];
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; len = '0; stuck = '0; load_en = 1'b0; load_val = '0;
        m_err = 1'b0; m_eidx = '0; m_q = '0;
        for (int i = 0; i < D; i++) m_table[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 1'b0, 1'b0, '0, '0, '0, '0);
        reset = 1'b0;
        tick();

        // Directed sequence from a cleared bank, both excitation styles in parallel
        for (int i = 0; i < 4; i++) write_entry(AW'(i), seq[i]);
        load_bank('0);
        run(4, '0, 1'b0);
        check("final_q0", 32'(bank0), 32'(2'b00));
        check("final_q1", 32'(bank1), 32'(2'b00));

        // Bit0 stuck low during the first step, then err must stay until the next start
        load_bank('0);
        run(4, 2'b01, 1'b0);
        tick();
        chk_outs("sticky", 1'b0, 1'b0, '0, '0, '0, '0);
        run(0, '0, 1'b0);

        // Writes and starts while busy are ignored; an idle write is used by the next run
        load_bank('0);
        run(4, '0, 1'b1);
        write_entry(AW'(2), 2'b01);
        load_bank('0);
        run(4, '0, 1'b0);

        // Randomized runs
        for (int it = 0; it < 30; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) write_entry(AW'($urandom), W'($urandom));
            load_bank(W'($urandom));
            run($urandom_range(0, D), ($urandom_range(0, 3) == 0) ? W'($urandom) : '0,
                ($urandom_range(0, 2) == 0));
        end

        // Reset during DRIVE of step 2 takes effect without a clock edge
        for (int i = 0; i < D; i++) write_entry(AW'(i), W'(i + 1));
        load_bank('0);
        start = 1'b1;
        len   = LW'(D);
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_busy0", 32'(busy0), 32'(1));
        reset = 1'b1;
        #1;
        m_err  = 1'b0;
        m_eidx = '0;
        for (int i = 0; i < D; i++) m_table[i] = '0;
        chk_outs("async_rst", 1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        reset = 1'b0;
        tick();
        load_bank(W'($urandom));
        run(D, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
